decode_stage_hz: RTL and testbench

- Parametrised pipelined decode (ID) stage for the 5-stage MIPS-subset core.
- Contents: register file, sign extension and main/ALU control decode, plus the ID/EX pipeline register with flush/bubble control, load-use hazard detection (drives StallF/StallD) and a saturating stall-cycle counter.
- Sits between the fetch (IF/ID) register and the execute stage.
- Exports RsE/RtE/RdE for the forwarding unit.

---
 rtl/decode_stage_hz_if.sv | 53 +++++
 rtl/decode_stage_hz.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_hz_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hz_if
// Description : Bundle of the decode-stage signals: fetched instruction,
//               writeback port, flush request, hazard outputs and the
//               registered ID/EX outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_hz_if #(
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 16
);
   logic [31:0]            InstructionD;
   logic [XLEN-1:0]        PCPlus4D;
   logic                   RegWriteW;
   logic [4:0]             WriteRegW;
   logic [XLEN-1:0]        ResultW;
   logic                   FlushE;
   logic                   StallF;
   logic                   StallD;
   logic [XLEN-1:0]        PCPlus4E;
   logic [XLEN-1:0]        SignImmE;
   logic [XLEN-1:0]        RD1E;
   logic [XLEN-1:0]        RD2E;
   logic [4:0]             RsE;
   logic [4:0]             RtE;
   logic [4:0]             RdE;
   logic                   RegWriteE;
   logic                   MemtoRegE;
   logic                   MemWriteE;
   logic                   BranchE;
   logic                   ALUSrcE;
   logic                   RegDstE;
   logic [2:0]             ALUControlE;
   logic [STALL_CNT_W-1:0] StallCount;

   // Surrounding pipeline: drives D/W-stage inputs, observes the stage.
   modport master (
      output InstructionD, PCPlus4D, RegWriteW, WriteRegW, ResultW, FlushE,
      input  StallF, StallD, PCPlus4E, SignImmE, RD1E, RD2E, RsE, RtE, RdE,
             RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE,
             ALUControlE, StallCount
   );

   // Decode stage itself.
   modport slave (
      input  InstructionD, PCPlus4D, RegWriteW, WriteRegW, ResultW, FlushE,
      output StallF, StallD, PCPlus4E, SignImmE, RD1E, RD2E, RsE, RtE, RdE,
             RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE,
             ALUControlE, StallCount
   );
endinterface
`default_nettype wire

// File: rtl/decode_stage_hz.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hz
// Description : MIPS-subset decode stage: register file, sign extension,
//               main/ALU control decode, ID/EX register with flush/bubble,
//               load-use hazard detection and saturating stall counter.
//               Optional macro DECODE_BYPASS_EN: register-file write-through
//               (otherwise a read of a register being written stalls).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_hz #(
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   decode_stage_hz_if.slave  bus
);
   logic [5:0]             w_op, w_funct;
   logic [4:0]             w_rs, w_rt, w_rd;
   logic [XLEN-1:0]        w_rd1, w_rd2, w_simm;
   logic                   w_wr_en;
   logic                   w_regwrite, w_memtoreg, w_memwrite, w_branch, w_alusrc, w_regdst;
   logic [2:0]             w_aluctl;
   logic                   w_lwstall, w_stall;

   logic [XLEN-1:0]        r_regs [32];
   logic [XLEN-1:0]        r_pc, r_simm, r_rd1, r_rd2;
   logic [4:0]             r_rs, r_rt, r_rd;
   logic                   r_regwrite, r_memtoreg, r_memwrite, r_branch, r_alusrc, r_regdst;
   logic [2:0]             r_aluctl;
   logic [STALL_CNT_W-1:0] r_cnt;

   assign w_op    = bus.InstructionD[31:26];
   assign w_rs    = bus.InstructionD[25:21];
   assign w_rt    = bus.InstructionD[20:16];
   assign w_rd    = bus.InstructionD[15:11];
   assign w_funct = bus.InstructionD[5:0];
   assign w_simm  = {{(XLEN-16){bus.InstructionD[15]}}, bus.InstructionD[15:0]};
   assign w_wr_en = bus.RegWriteW && (bus.WriteRegW != 5'd0);

   // Register file storage; cleared on reset, $0 never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[bus.WriteRegW] <= bus.ResultW;
      end
   end

`ifdef DECODE_BYPASS_EN
   // Combinational reads with same-cycle write-through from writeback.
   always_comb begin
      w_rd1 = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
      w_rd2 = (w_rt == 5'd0) ? '0 : r_regs[w_rt];
      if (w_wr_en && (bus.WriteRegW == w_rs)) w_rd1 = bus.ResultW;
      if (w_wr_en && (bus.WriteRegW == w_rt)) w_rd2 = bus.ResultW;
   end
   assign w_stall = w_lwstall;
`else
   logic w_wstall;
   // Combinational reads return the stored value; a pending write stalls instead.
   always_comb begin
      w_rd1 = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
      w_rd2 = (w_rt == 5'd0) ? '0 : r_regs[w_rt];
   end
   assign w_wstall = w_wr_en && ((bus.WriteRegW == w_rs) || (bus.WriteRegW == w_rt));
   assign w_stall  = w_lwstall | w_wstall;
`endif

   // Main and ALU control decode; unsupported encodings decode as nop.
   always_comb begin
      w_regwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_memwrite = 1'b0;
      w_branch   = 1'b0;
      w_alusrc   = 1'b0;
      w_regdst   = 1'b0;
      w_aluctl   = 3'b000;
      case (w_op)
         6'b000000: begin
            w_regwrite = 1'b1;
            w_regdst   = 1'b1;
            case (w_funct)
               6'b100000: w_aluctl = 3'b010;
               6'b100010: w_aluctl = 3'b110;
               6'b100100: w_aluctl = 3'b000;
               6'b100101: w_aluctl = 3'b001;
               6'b101010: w_aluctl = 3'b111;
               default: begin
                  w_regwrite = 1'b0;
                  w_regdst   = 1'b0;
               end
            endcase
         end
         6'b100011: begin
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_memtoreg = 1'b1;
            w_aluctl   = 3'b010;
         end
         6'b101011: begin
            w_memwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_aluctl   = 3'b010;
         end
         6'b000100: begin
            w_branch = 1'b1;
            w_aluctl = 3'b110;
         end
         6'b001000: begin
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_aluctl   = 3'b010;
         end
         default: ;
      endcase
   end

   assign w_lwstall  = r_memtoreg && (r_rt != 5'd0) && ((r_rt == w_rs) || (r_rt == w_rt));
   assign bus.StallF = w_stall;
   assign bus.StallD = w_stall;

   // ID/EX register: reset, then bubble on flush or stall, else capture D.
   always_ff @(posedge clk) begin
      if (rst || bus.FlushE || w_stall) begin
         r_pc       <= '0;
         r_simm     <= '0;
         r_rd1      <= '0;
         r_rd2      <= '0;
         r_rs       <= 5'd0;
         r_rt       <= 5'd0;
         r_rd       <= 5'd0;
         r_regwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_memwrite <= 1'b0;
         r_branch   <= 1'b0;
         r_alusrc   <= 1'b0;
         r_regdst   <= 1'b0;
         r_aluctl   <= 3'b000;
      end else begin
         r_pc       <= bus.PCPlus4D;
         r_simm     <= w_simm;
         r_rd1      <= w_rd1;
         r_rd2      <= w_rd2;
         r_rs       <= w_rs;
         r_rt       <= w_rt;
         r_rd       <= w_rd;
         r_regwrite <= w_regwrite;
         r_memtoreg <= w_memtoreg;
         r_memwrite <= w_memwrite;
         r_branch   <= w_branch;
         r_alusrc   <= w_alusrc;
         r_regdst   <= w_regdst;
         r_aluctl   <= w_aluctl;
      end
   end

   // Stall-cycle counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_stall && (r_cnt != {STALL_CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + STALL_CNT_W'(1);
      end
   end

   assign bus.PCPlus4E    = r_pc;
   assign bus.SignImmE    = r_simm;
   assign bus.RD1E        = r_rd1;
   assign bus.RD2E        = r_rd2;
   assign bus.RsE         = r_rs;
   assign bus.RtE         = r_rt;
   assign bus.RdE         = r_rd;
   assign bus.RegWriteE   = r_regwrite;
   assign bus.MemtoRegE   = r_memtoreg;
   assign bus.MemWriteE   = r_memwrite;
   assign bus.BranchE     = r_branch;
   assign bus.ALUSrcE     = r_alusrc;
   assign bus.RegDstE     = r_regdst;
   assign bus.ALUControlE = r_aluctl;
   assign bus.StallCount  = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hz.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_hz
// Description : Self-checking bench for decode_stage_hz: directed scenarios
//               with literal expectations, then randomized traffic against a
//               behavioural model. A second instance with a 2-bit stall
//               counter shares the stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_hz;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_stage_hz_if #(.XLEN(32), .STALL_CNT_W(16)) dif ();
   decode_stage_hz_if #(.XLEN(32), .STALL_CNT_W(2))  dif2 ();

   decode_stage_hz #(.XLEN(32), .STALL_CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(dif));
   decode_stage_hz #(.XLEN(32), .STALL_CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(dif2));

   int nvec = 0;
   int nerr = 0;

   // Behavioural model state
   logic [31:0] m_regs [32];
   logic [31:0] m_pc, m_imm, m_rd1, m_rd2;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic [8:0]  m_ctl;   // {RegWrite,MemtoReg,MemWrite,Branch,ALUSrc,RegDst,ALUControl[2:0]}
   int          m_cnt;
   bit          m_valid = 1'b0;

   function automatic logic [8:0] ctl_of(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'b000000) begin
         if (fn == 6'b100000) return 9'b100001010;
         if (fn == 6'b100010) return 9'b100001110;
         if (fn == 6'b100100) return 9'b100001000;
         if (fn == 6'b100101) return 9'b100001001;
         if (fn == 6'b101010) return 9'b100001111;
         return 9'b0;
      end
      if (op == 6'b100011) return 9'b110010010;
      if (op == 6'b101011) return 9'b001010010;
      if (op == 6'b000100) return 9'b000100110;
      if (op == 6'b001000) return 9'b100010010;
      return 9'b0;
   endfunction

   function automatic logic [8:0] dut_ctl();
      return {dif.RegWriteE, dif.MemtoRegE, dif.MemWriteE, dif.BranchE,
              dif.ALUSrcE, dif.RegDstE, dif.ALUControlE};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      int sat;
      sat = (m_cnt > 3) ? 3 : m_cnt;
      chk("PCPlus4E", 64'(dif.PCPlus4E), 64'(m_pc));
      chk("SignImmE", 64'(dif.SignImmE), 64'(m_imm));
      chk("RD1E", 64'(dif.RD1E), 64'(m_rd1));
      chk("RD2E", 64'(dif.RD2E), 64'(m_rd2));
      chk("RsE", 64'(dif.RsE), 64'(m_rs));
      chk("RtE", 64'(dif.RtE), 64'(m_rt));
      chk("RdE", 64'(dif.RdE), 64'(m_rd));
      chk("ctlE", 64'(dut_ctl()), 64'(m_ctl));
      chk("StallCount", 64'(dif.StallCount), 64'(m_cnt));
      chk("StallCount2", 64'(dif2.StallCount), 64'(sat));
   endtask

   // One clock cycle: drive, check hazard outputs, clock, update model, check E.
   task automatic cyc(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rw, input logic [4:0] wr, input logic [31:0] res,
                      input logic fl, output logic sd);
      logic [4:0]  rs, rt;
      logic [31:0] rd1, rd2;
      logic        wen, lw, ws, st;
      rst = r;
      dif.InstructionD = ins;  dif2.InstructionD = ins;
      dif.PCPlus4D     = pc;   dif2.PCPlus4D     = pc;
      dif.RegWriteW    = rw;   dif2.RegWriteW    = rw;
      dif.WriteRegW    = wr;   dif2.WriteRegW    = wr;
      dif.ResultW      = res;  dif2.ResultW      = res;
      dif.FlushE       = fl;   dif2.FlushE       = fl;
      rs  = ins[25:21];
      rt  = ins[20:16];
      wen = rw && (wr != 5'd0);
      rd1 = (rs == 5'd0) ? 32'd0 : m_regs[rs];
      rd2 = (rt == 5'd0) ? 32'd0 : m_regs[rt];
      lw  = m_ctl[7] && (m_rt != 5'd0) && ((m_rt == rs) || (m_rt == rt));
`ifdef DECODE_BYPASS_EN
      if (wen && wr == rs) rd1 = res;
      if (wen && wr == rt) rd2 = res;
      ws = 1'b0;
`else
      ws = wen && ((wr == rs) || (wr == rt));
`endif
      st = lw || ws;
      #1;
      sd = dif.StallD;
      if (m_valid) begin
         chk("StallD", 64'(dif.StallD), 64'(st));
         chk("StallF", 64'(dif.StallF), 64'(st));
         chk("StallD2", 64'(dif2.StallD), 64'(st));
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         {m_pc, m_imm, m_rd1, m_rd2} = '0;
         {m_rs, m_rt, m_rd} = '0;
         m_ctl = 9'd0;
         m_cnt = 0;
         m_valid = 1'b1;
      end else begin
         if (wen) m_regs[wr] = res;
         if (fl || st) begin
            {m_pc, m_imm, m_rd1, m_rd2} = '0;
            {m_rs, m_rt, m_rd} = '0;
            m_ctl = 9'd0;
         end else begin
            m_pc  = pc;
            m_imm = {{16{ins[15]}}, ins[15:0]};
            m_rd1 = rd1;
            m_rd2 = rd2;
            m_rs  = rs;
            m_rt  = rt;
            m_rd  = ins[15:11];
            m_ctl = ctl_of(ins);
         end
         if (st && m_cnt < 65535) m_cnt++;
      end
      @(negedge clk);
      if (m_valid) check_all();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  fn;
      int          k;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 5))
         0: fn = 6'b100000;
         1: fn = 6'b100010;
         2: fn = 6'b100100;
         3: fn = 6'b100101;
         4: fn = 6'b101010;
         default: fn = 6'($urandom);
      endcase
      k = $urandom_range(0, 7);
      case (k)
         0, 1: return {6'b000000, rs, rt, rd, 5'd0, fn};
         2, 3: return {6'b100011, rs, rt, imm};
         4:    return {6'b101011, rs, rt, imm};
         5:    return {6'b000100, rs, rt, imm};
         6:    return {6'b001000, rs, rt, imm};
         default: return {6'b111111, rs, rt, imm};
      endcase
   endfunction

   localparam logic [31:0] ADD321 = 32'h00221820;  // add $3,$1,$2
   localparam logic [31:0] LW2    = 32'h8C020000;  // lw  $2,0($0)

   initial begin
      logic sd;
      rst = 1'b1;
      @(negedge clk);

      // Reset
      cyc(1, ADD321, 32'd4, 0, 0, 0, 0, sd);
      cyc(1, ADD321, 32'd4, 0, 0, 0, 0, sd);
      chk("rst_ctl", 64'(dut_ctl()), 64'd0);
      chk("rst_rd1", 64'(dif.RD1E), 64'd0);
      chk("rst_cnt", 64'(dif.StallCount), 64'd0);
      chk("rst_stalld", 64'(dif.StallD), 64'd0);

      // Register file write then decode of add
      cyc(0, 32'd0, 32'd8, 1, 5'd1, 32'd5, 0, sd);
      cyc(0, 32'd0, 32'd8, 1, 5'd2, 32'd7, 0, sd);
      cyc(0, ADD321, 32'h100, 0, 0, 0, 0, sd);
      chk("add_rd1", 64'(dif.RD1E), 64'd5);
      chk("add_rd2", 64'(dif.RD2E), 64'd7);
      chk("add_rd", 64'(dif.RdE), 64'd3);
      chk("add_ctl", 64'(dut_ctl()), 64'h10A);
      chk("add_pc", 64'(dif.PCPlus4E), 64'h100);

      // Load-use
      cyc(0, LW2, 32'h104, 0, 0, 0, 0, sd);
      cyc(0, ADD321, 32'h108, 0, 0, 0, 0, sd);
      chk("lu_stall", 64'(sd), 64'd1);
      chk("lu_bubble", 64'(dut_ctl()), 64'd0);
      chk("lu_cnt", 64'(dif.StallCount), 64'd1);
      cyc(0, ADD321, 32'h108, 0, 0, 0, 0, sd);
      chk("lu_nostall", 64'(sd), 64'd0);
      chk("lu_add", 64'(dut_ctl()), 64'h10A);

      // Flush with beq in decode
      cyc(0, 32'h10220003, 32'h10C, 0, 0, 0, 1, sd);
      chk("fl_ctl", 64'(dut_ctl()), 64'd0);
      chk("fl_cnt", 64'(dif.StallCount), 64'd1);

      // Writeback conflict on $1
      cyc(0, ADD321, 32'h110, 1, 5'd1, 32'hDEAD, 0, sd);
`ifdef DECODE_BYPASS_EN
      chk("wc_stall", 64'(sd), 64'd0);
      chk("wc_rd1", 64'(dif.RD1E), 64'hDEAD);
`else
      chk("wc_stall", 64'(sd), 64'd1);
      cyc(0, ADD321, 32'h110, 0, 0, 0, 0, sd);
      chk("wc_rd1", 64'(dif.RD1E), 64'hDEAD);
      chk("wc_cnt", 64'(dif.StallCount), 64'd2);
`endif

      // Write to $0 is discarded
      cyc(0, 32'd0, 32'h114, 1, 5'd0, 32'hFFFF, 0, sd);
      cyc(0, 32'h00021820, 32'h118, 0, 0, 0, 0, sd);
      chk("r0_rd1", 64'(dif.RD1E), 64'd0);

      // Unknown opcode decodes as nop
      cyc(0, 32'hFC221820, 32'h11C, 0, 0, 0, 0, sd);
      chk("badop_ctl", 64'(dut_ctl()), 64'd0);

      // Saturation of the 2-bit counter over five stalls
      cyc(1, 32'd0, 32'd0, 0, 0, 0, 0, sd);
      for (int i = 0; i < 5; i++) begin
         cyc(0, LW2, 32'h200, 0, 0, 0, 0, sd);
         cyc(0, ADD321, 32'h204, 0, 0, 0, 0, sd);
      end
      chk("sat_cnt2", 64'(dif2.StallCount), 64'd3);
      chk("sat_cnt16", 64'(dif.StallCount), 64'd5);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
             rand_instr(), $urandom,
             ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, sd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
`default_nettype wire
